// File: rtl/wb_cmd_master.sv
// ============================================================================
// Module      : wb_cmd_master
// Description : Single-outstanding command to Wishbone classic master with
//               retry handling. Optional bus timeout via WB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_master #(
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    // response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_status,
    // wishbone master
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_RETRY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int            RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]    rsp_status_q, rsp_status_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [1:0] ST_TMO = 2'b11;
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            retry_q      <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            retry_q      <= retry_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        retry_d      = retry_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    retry_d = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // termination priority: err over ack over rty
                if (wb_err_i) begin
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else if (wb_ack_i) begin
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = we_q ? 32'd0 : wb_dat_i;
                    state_d      = S_RESP;
                end else if (wb_rty_i) begin
                    if (retry_q == RETRY_LIMIT) begin
                        rsp_status_d = ST_RTY;
                        rsp_dat_d    = '0;
                        state_d      = S_RESP;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RETRY;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rsp_status_d = ST_TMO;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RETRY: begin
`ifdef WB_MASTER_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rst_n gating keeps cmd_ready low while reset is held
    assign cmd_ready  = rst_n && (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;

    assign wb_cyc_o   = (state_q == S_BUS);
    assign wb_stb_o   = (state_q == S_BUS);
    assign wb_we_o    = (state_q == S_BUS) && we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed commands against a scripted Wishbone responder.
`default_nettype none

module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0] wb_dat_i;
    logic        busy;

    wb_cmd_master #(.MAX_RETRY(3), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_dat_i(wb_dat_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    // responder script: rty_n retries, then mode 0=ack, 1=err+ack, 2=never terminate
    int attempts  = 0;
    int we_cycles = 0;
    int rty_n     = 0;
    int mode      = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (wb_cyc_o && wb_stb_o) begin
            attempts++;
            if (wb_we_o) we_cycles++;
            wb_rty_i = (attempts <= rty_n);
            wb_ack_i = (attempts > rty_n) && (mode != 2);
            wb_err_i = (attempts > rty_n) && (mode == 1);
        end else begin
            wb_rty_i = 1'b0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {rsp_status, rsp_dat}, 34'h3_FFFF_FFFF);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("rsp_status", {32'd0, rsp_status}, {32'd0, e[33:32]});
                chk("rsp_dat", {2'd0, rsp_dat}, {2'd0, e[31:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns one cycle after the accepting edge
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int n_rty, input int m, input bit push, input logic [33:0] exp);
        int guard;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = 4'hF;
        rty_n = n_rty; mode = m; attempts = 0; we_cycles = 0;
        if (push) exp_q.push_back(exp);
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin tick(); guard++; end
        if (guard >= 100) chk("accept_timeout", {33'd0, cmd_ready}, 34'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // cycles from accept edge until rsp_valid seen
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 2000) begin tick(); n++; end
        if (!rsp_valid) chk("rsp_timeout", {33'd0, rsp_valid}, 34'd1);
    endtask

    initial begin
        int n;
        int hi;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b1; wb_dat_i = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {33'd0, cmd_ready}, 34'd0);
        chk("rst_cyc_stb", {32'd0, wb_cyc_o, wb_stb_o}, 34'd0);
        chk("rst_busy_rsp", {32'd0, busy, rsp_valid}, 34'd0);
        chk("rst_adr", {2'd0, wb_adr_o}, 34'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {33'd0, cmd_ready}, 34'd1);

        // zero-wait write
        issue(1'b1, 32'h100, 32'hDEADBEEF, 0, 0, 1'b1, {2'b00, 32'd0});
        chk("wr_bus", {31'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 34'd7);
        chk("wr_adr", {2'd0, wb_adr_o}, {2'd0, 32'h100});
        chk("wr_dat_sel", {2'd0, wb_dat_o}, {2'd0, 32'hDEADBEEF});
        chk("wr_sel", {30'd0, wb_sel_o}, 34'hF);
        wait_rsp(n);
        chk("wr_latency", 34'(n), 34'd2);
        tick();
        chk("wr_we_cycles", 34'(we_cycles), 34'd1);
        chk("wr_idle_ready", {33'd0, cmd_ready}, 34'd1);

        // read with held response
        rsp_ready = 1'b0;
        wb_dat_i  = 32'hDEADBEEF;
        issue(1'b0, 32'h100, 32'h0, 0, 0, 1'b1, {2'b00, 32'hDEADBEEF});
        wait_rsp(n);
        chk("rd_latency", 34'(n), 34'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_hold", {rsp_status, rsp_dat}, {2'b00, 32'hDEADBEEF});
            chk("rd_hold_ctl", {32'd0, rsp_valid, cmd_ready}, 34'd2);
        end
        rsp_ready = 1'b1;
        tick();

        // three retries then ack
        wb_dat_i = 32'hCAFEF00D;
        issue(1'b0, 32'h200, 32'h0, 3, 0, 1'b1, {2'b00, 32'hCAFEF00D});
        wait_rsp(n);
        chk("rty3_latency", 34'(n), 34'd8);
        tick();
        chk("rty3_attempts", 34'(attempts), 34'd4);

        // retries exhausted
        issue(1'b0, 32'h204, 32'h0, 4, 0, 1'b1, {2'b10, 32'd0});
        wait_rsp(n);
        chk("rty4_latency", 34'(n), 34'd8);
        tick();
        chk("rty4_attempts", 34'(attempts), 34'd4);

        // err and ack together
        wb_dat_i = 32'h12345678;
        issue(1'b0, 32'h300, 32'h0, 0, 1, 1'b1, {2'b01, 32'd0});
        wait_rsp(n);
        chk("err_latency", 34'(n), 34'd2);
        tick();

`ifdef WB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'h400, 32'h0, 0, 2, 1'b1, {2'b11, 32'd0});
        wait_rsp(n);
        chk("tmo_latency", 34'(n), 34'd9);
        tick();
        chk("tmo_cyc_cycles", 34'(attempts), 34'd8);
        issue(1'b1, 32'h500, 32'h55, 0, 2, 1'b0, 34'd0);
        repeat (2) tick();
`else
        issue(1'b1, 32'h500, 32'h55, 0, 2, 1'b0, 34'd0);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            if (wb_cyc_o) hi++;
            tick();
        end
        chk("hang_cyc_cycles", 34'(hi), 34'd1000);
`endif
        // asynchronous reset in the middle of a bus cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc_stb", {32'd0, wb_cyc_o, wb_stb_o}, 34'd0);
        chk("arst_busy_rsp", {32'd0, busy, rsp_valid}, 34'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        issue(1'b1, 32'h600, 32'hA5A5A5A5, 0, 0, 1'b1, {2'b00, 32'd0});
        wait_rsp(n);
        chk("post_arst_latency", 34'(n), 34'd2);
        repeat (3) tick();
        chk("scoreboard_empty", 34'(exp_q.size()), 34'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
